// File: rtl/filt_mac_pkg.sv
// Shared types and constant helpers for the multichannel FIR MAC scheduler.
package filt_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MAC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Index width for n items, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w = w + 1;
    if (w == 0) w = 1;
    return w;
  endfunction

  // MAC steps per result: symmetric filters fold tap pairs.
  function automatic int unsigned calc_k(input int unsigned len, input bit symm);
    return symm ? (len + 1) / 2 : len;
  endfunction

  // (a + b) mod m for a, b < m; compare-and-subtract keeps non-power-of-2 wrap exact.
  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                          input int unsigned m);
    int unsigned s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

endpackage

// File: rtl/filt_mac_rr_arb.sv
// Combinational round-robin arbiter: first pending channel at or after rr_ptr.
module filt_mac_rr_arb
  import filt_mac_pkg::*;
#(
  parameter int unsigned gp_num_ch = 2,
  localparam int unsigned ch_w = clog2_min1(gp_num_ch)
) (
  input  logic [gp_num_ch-1:0] pending,
  input  logic [ch_w-1:0]      rr_ptr,
  output logic [ch_w-1:0]      grant,
  output logic                 grant_vld
);

  logic [31:0] pend_ext;
  logic [31:0] idx;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    pend_ext  = 32'(pending);
    for (int unsigned i = 0; i < gp_num_ch; i++) begin
      idx = mod_add(32'(rr_ptr), i, gp_num_ch);
      if (!grant_vld && pend_ext[idx[4:0]]) begin
        grant     = ch_w'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/filt_mac_sched.sv
// Time-shares one serial FIR MAC between channels: request tracking, round-robin
// service, per-channel circular delay-line heads and MAC address/strobe sequencing.
module filt_mac_sched
  import filt_mac_pkg::*;
#(
  parameter int unsigned gp_num_ch       = 2,
  parameter int unsigned gp_coeff_length = 16,
  parameter int unsigned gp_symm         = 1,
  localparam int unsigned ch_w   = clog2_min1(gp_num_ch),
  localparam int unsigned addr_w = clog2_min1(gp_coeff_length),
  localparam int unsigned k_len  = calc_k(gp_coeff_length, gp_symm != 0),
  localparam int unsigned k_w    = clog2_min1(k_len)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ena,
  input  logic [gp_num_ch-1:0] i_smp_vld,
  output logic [ch_w-1:0]      o_ch,
  output logic                 o_wr_en,
  output logic [addr_w-1:0]    o_wr_addr,
  output logic [addr_w-1:0]    o_rd_addr_a,
  output logic [addr_w-1:0]    o_rd_addr_b,
  output logic [k_w-1:0]       o_coeff_addr,
  output logic                 o_acc_clr,
  output logic                 o_acc_en,
  output logic                 o_fold_en,
  output logic                 o_done,
  output logic [ch_w-1:0]      o_done_ch,
  output logic                 o_busy,
  output logic [gp_num_ch-1:0] o_ovf
);

  localparam int unsigned n_heads = 2 ** ch_w;
  localparam bit          l_odd   = (gp_coeff_length % 2) == 1;

  state_t                 state, state_n;
  logic [k_w-1:0]         kcnt, kcnt_n;
  logic [ch_w-1:0]        cur_ch, cur_ch_n;
  logic [ch_w-1:0]        rr_ptr, rr_ptr_n;
  logic [gp_num_ch-1:0]   pending, pending_n;
  logic [addr_w-1:0]      head [n_heads];
  logic [addr_w-1:0]      head_n [n_heads];

  logic [ch_w-1:0]        ch_n, done_ch_n;
  logic                   wr_en_n, acc_clr_n, acc_en_n, fold_n, done_n, busy_n;
  logic [addr_w-1:0]      wr_addr_n, rd_a_n, rd_b_n;
  logic [k_w-1:0]         coeff_n;
  logic [gp_num_ch-1:0]   ovf_n, clr;
  logic [addr_w-1:0]      new_head, cur_head;
  logic                   last_k;

  logic [ch_w-1:0]        grant;
  logic                   grant_vld;

  filt_mac_rr_arb #(
    .gp_num_ch (gp_num_ch)
  ) u_arb (
    .pending   (pending),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  // Next-state and registered-output values; strobes default low, addresses hold.
  always_comb begin
    state_n   = state;
    kcnt_n    = kcnt;
    cur_ch_n  = cur_ch;
    rr_ptr_n  = rr_ptr;
    head_n    = head;
    ch_n      = o_ch;
    wr_en_n   = 1'b0;
    wr_addr_n = o_wr_addr;
    rd_a_n    = o_rd_addr_a;
    rd_b_n    = o_rd_addr_b;
    coeff_n   = o_coeff_addr;
    acc_clr_n = 1'b0;
    acc_en_n  = 1'b0;
    fold_n    = o_fold_en;
    done_n    = 1'b0;
    done_ch_n = o_done_ch;
    busy_n    = o_busy;
    clr       = '0;
    new_head  = addr_w'(mod_add(32'(head[grant]), gp_coeff_length - 1, gp_coeff_length));
    cur_head  = head[cur_ch];
    last_k    = (kcnt == k_w'(k_len - 1));

    if (i_ena) begin
      busy_n = (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (|pending) state_n = ST_LOAD;
        end
        ST_LOAD: begin
          if (grant_vld) begin
            cur_ch_n       = grant;
            ch_n           = grant;
            head_n[grant]  = new_head;
            wr_en_n        = 1'b1;
            wr_addr_n      = new_head;
            fold_n         = 1'b0;
            clr            = gp_num_ch'(1) << grant;
            rr_ptr_n       = ch_w'(mod_add(32'(grant), 1, gp_num_ch));
            kcnt_n         = '0;
            state_n        = ST_MAC;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_MAC: begin
          acc_en_n  = 1'b1;
          acc_clr_n = (kcnt == '0);
          coeff_n   = kcnt;
          rd_a_n    = addr_w'(mod_add(32'(cur_head), 32'(kcnt), gp_coeff_length));
          rd_b_n    = addr_w'(mod_add(32'(cur_head), gp_coeff_length - 1 - 32'(kcnt),
                                      gp_coeff_length));
          // The middle tap of an odd-length symmetric filter has no partner.
          fold_n    = (gp_symm != 0) && !(l_odd && last_k);
          if (last_k) state_n = ST_DONE;
          else        kcnt_n  = kcnt + k_w'(1);
        end
        ST_DONE: begin
          done_n    = 1'b1;
          done_ch_n = cur_ch;
          fold_n    = 1'b0;
          state_n   = (|pending) ? ST_LOAD : ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end

    // A request arriving while its channel is loaded re-arms it without overrun.
    pending_n = (pending & ~clr) | i_smp_vld;
    ovf_n     = o_ovf | (i_smp_vld & pending & ~clr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      kcnt         <= '0;
      cur_ch       <= '0;
      rr_ptr       <= '0;
      pending      <= '0;
      head         <= '{default: '0};
      o_ch         <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_rd_addr_a  <= '0;
      o_rd_addr_b  <= '0;
      o_coeff_addr <= '0;
      o_acc_clr    <= 1'b0;
      o_acc_en     <= 1'b0;
      o_fold_en    <= 1'b0;
      o_done       <= 1'b0;
      o_done_ch    <= '0;
      o_busy       <= 1'b0;
      o_ovf        <= '0;
    end else begin
      state        <= state_n;
      kcnt         <= kcnt_n;
      cur_ch       <= cur_ch_n;
      rr_ptr       <= rr_ptr_n;
      pending      <= pending_n;
      head         <= head_n;
      o_ch         <= ch_n;
      o_wr_en      <= wr_en_n;
      o_wr_addr    <= wr_addr_n;
      o_rd_addr_a  <= rd_a_n;
      o_rd_addr_b  <= rd_b_n;
      o_coeff_addr <= coeff_n;
      o_acc_clr    <= acc_clr_n;
      o_acc_en     <= acc_en_n;
      o_fold_en    <= fold_n;
      o_done       <= done_n;
      o_done_ch    <= done_ch_n;
      o_busy       <= busy_n;
      o_ovf        <= ovf_n;
    end
  end

endmodule

// File: tb/tb_filt_mac_sched.sv
// Scoreboard bench for filt_mac_sched: an event-level schedule model predicts every
// LOAD / MAC step / DONE; a monitor compares DUT activity against that queue.
module tb_filt_mac_sched;

  localparam int N    = 2;
  localparam int L    = 16;
  localparam int SYMM = 1;
  localparam int K    = (SYMM != 0) ? (L + 1) / 2 : L;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [1:0] vld = 2'b00;
  logic       vld1 = 1'b0;

  logic       o_ch, o_wr_en, o_acc_clr, o_acc_en, o_fold_en, o_done, o_done_ch, o_busy;
  logic [3:0] o_wr_addr, o_rd_a, o_rd_b;
  logic [2:0] o_coeff;
  logic [1:0] o_ovf;

  logic       d1_ch, d1_wr_en, d1_acc_clr, d1_acc_en, d1_fold, d1_done, d1_done_ch, d1_busy;
  logic [3:0] d1_wr_addr, d1_rd_a, d1_rd_b;
  logic [2:0] d1_coeff;
  logic       d1_ovf;

  filt_mac_sched #(.gp_num_ch(N), .gp_coeff_length(L), .gp_symm(SYMM)) dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_smp_vld(vld),
    .o_ch(o_ch), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_rd_addr_a(o_rd_a), .o_rd_addr_b(o_rd_b), .o_coeff_addr(o_coeff),
    .o_acc_clr(o_acc_clr), .o_acc_en(o_acc_en), .o_fold_en(o_fold_en),
    .o_done(o_done), .o_done_ch(o_done_ch), .o_busy(o_busy), .o_ovf(o_ovf)
  );

  filt_mac_sched #(.gp_num_ch(1), .gp_coeff_length(15), .gp_symm(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_ena(1'b1), .i_smp_vld(vld1),
    .o_ch(d1_ch), .o_wr_en(d1_wr_en), .o_wr_addr(d1_wr_addr),
    .o_rd_addr_a(d1_rd_a), .o_rd_addr_b(d1_rd_b), .o_coeff_addr(d1_coeff),
    .o_acc_clr(d1_acc_clr), .o_acc_en(d1_acc_en), .o_fold_en(d1_fold),
    .o_done(d1_done), .o_done_ch(d1_done_ch), .o_busy(d1_busy), .o_ovf(d1_ovf)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // cyc is the index of the last active edge; the first edge out of reset is 0.
  always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

  typedef struct packed {
    int cyc; int kind; int ch; int a; int b; int c; int f;
  } ev_t;

  ev_t        exp_q[$];
  bit         mon_en = 1'b0;
  bit [1:0]   tab[$];
  int         m_head[N];
  int         m_rr;
  int         m_free;
  bit [N-1:0] m_ovf;

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic string ev_str(input ev_t e);
    return $sformatf("cyc=%0d kind=%0d ch=%0d a=%0d b=%0d c=%0d f=%0d",
                     e.cyc, e.kind, e.ch, e.a, e.b, e.c, e.f);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_head[i] = 0;
    m_rr = 0; m_free = 0; m_ovf = '0;
  endfunction

  // One service: LOAD at edge e, K MAC steps, then DONE.
  function automatic void m_serve(input int c, input int e);
    int h;
    bit fold;
    m_head[c] = (m_head[c] + L - 1) % L;
    h = m_head[c];
    exp_q.push_back('{e, 0, c, h, 0, 0, 0});
    for (int k = 0; k < K; k++) begin
      fold = (SYMM != 0) && !((L % 2 == 1) && (k == K - 1));
      exp_q.push_back('{e + 1 + k, 1, c, (h + k) % L, (h + L - 1 - k) % L, k,
                        ((k == 0) ? 2 : 0) + (fold ? 1 : 0)});
    end
    exp_q.push_back('{e + K + 1, 2, c, 0, 0, 0, 0});
    m_rr   = (c + 1) % N;
    m_free = e + K + 1;
  endfunction

  // Requests in tab[i] are sampled at edge S+i. The scheduler decides at each edge
  // from its DONE edge on using requests from earlier edges; LOAD follows one edge later.
  function automatic void m_run(input int S);
    bit [N-1:0] pend;
    int load_e, T, c, pick;
    pend = '0; load_e = -1; T = tab.size();
    for (int e = S; e < S + T + 10000; e++) begin
      if (e >= S + T && pend == '0 && load_e < 0) break;
      if (e == load_e) begin
        pick = -1;
        for (int i = 0; i < N; i++) begin
          c = (m_rr + i) % N;
          if (pick < 0 && pend[c]) pick = c;
        end
        if (pick >= 0) begin
          m_serve(pick, e);
          pend[pick] = 1'b0;
        end
        load_e = -1;
      end else if (load_e < 0 && e >= m_free && pend != '0) begin
        load_e = e + 1;
      end
      if (e < S + T) begin
        for (int ch = 0; ch < N; ch++) begin
          if (tab[e - S][ch]) begin
            if (pend[ch]) m_ovf[ch] = 1'b1;
            pend[ch] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic mon_cmp(input ev_t act);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 1'b0, $sformatf("got %s, need none", ev_str(act)));
    end else begin
      e = exp_q.pop_front();
      check("event", act == e, $sformatf("got %s, need %s", ev_str(act), ev_str(e)));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (o_wr_en) mon_cmp('{cyc, 0, int'(o_ch), int'(o_wr_addr), 0, 0, 0});
      if (o_acc_en) mon_cmp('{cyc, 1, int'(o_ch), int'(o_rd_a), int'(o_rd_b), int'(o_coeff),
                              (o_acc_clr ? 2 : 0) + (o_fold_en ? 1 : 0)});
      if (o_done) mon_cmp('{cyc, 2, int'(o_done_ch), 0, 0, 0, 0});
    end
  end

  // Called at a negedge: predicts, drives tab, then drains the scoreboard.
  task automatic run_phase(input string name);
    int S, n;
    S = cyc + 1;
    m_run(S);
    foreach (tab[i]) begin
      vld = tab[i];
      @(negedge clk);
    end
    vld = 2'b00;
    check({name, "_ovf"}, o_ovf == m_ovf,
          $sformatf("got ovf=%b need %b", o_ovf, m_ovf));
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, exp_q.size() == 0,
          $sformatf("got %0d events outstanding need 0", exp_q.size()));
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  int s, done_cnt, done_at, ka, kb;

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outputs",
          {o_ch, o_wr_en, o_wr_addr, o_rd_a, o_rd_b, o_coeff, o_acc_clr, o_acc_en,
           o_fold_en, o_done, o_done_ch, o_ovf} == '0,
          $sformatf("got wr_en=%0d acc_en=%0d done=%0d ovf=%b addr=%0d need all 0",
                    o_wr_en, o_acc_en, o_done, o_ovf, o_wr_addr));
    check("reset_busy", o_busy == 1'b0, $sformatf("got busy=%0d need 0", o_busy));
    mon_en = 1'b1;

    // Single channel-0 request at edge 10.
    tab.delete();
    for (int i = 0; i < 11; i++) tab.push_back(2'b00);
    tab[10] = 2'b01;
    run_phase("single");

    // Simultaneous pair twice: round-robin restarts at channel 0.
    tab.delete();
    for (int i = 0; i < 40; i++) tab.push_back(2'b00);
    tab[0] = 2'b11;
    tab[30] = 2'b11;
    run_phase("pair");

    // Back-to-back channel-1 requests: merged, overrun flagged.
    tab.delete();
    tab.push_back(2'b10); tab.push_back(2'b10); tab.push_back(2'b00);
    run_phase("overrun");

    // Random request traffic.
    tab.delete();
    for (int i = 0; i < 300; i++)
      tab.push_back({2'($urandom_range(0, 11) == 0), 2'($urandom_range(0, 11) == 0)} == 2'b00
                    ? 2'b00
                    : {1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 11) == 0)});
    for (int i = 0; i < 300; i += 7) tab[i] = 2'($urandom_range(0, 3));
    run_phase("random");

    // Odd-length symmetric filter on the single-channel instance.
    vld1 = 1'b1;
    @(negedge clk);
    vld1 = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j == 2) begin
        check("odd_load", d1_wr_en && d1_wr_addr == 4'd14,
              $sformatf("got wr_en=%0d addr=%0d need 1/14", d1_wr_en, d1_wr_addr));
      end else if (j >= 3 && j <= 10) begin
        ka = (14 + (j - 3)) % 15;
        kb = (28 - (j - 3)) % 15;
        check("odd_step",
              d1_acc_en && d1_rd_a == 4'(ka) && d1_rd_b == 4'(kb) &&
              d1_coeff == 3'(j - 3) && d1_fold == ((j - 3) < 7),
              $sformatf("got en=%0d a=%0d b=%0d k=%0d fold=%0d need 1/%0d/%0d/%0d/%0d",
                        d1_acc_en, d1_rd_a, d1_rd_b, d1_coeff, d1_fold, ka, kb, j - 3,
                        ((j - 3) < 7)));
      end else if (j == 11) begin
        check("odd_done", d1_done, $sformatf("got done=%0d need 1", d1_done));
      end
    end
    repeat (3) @(negedge clk);

    // Reset at MAC step 4 aborts without a result.
    mon_en = 1'b0;
    vld = 2'b01;
    @(negedge clk);
    s = cyc;
    vld = 2'b00;
    while (cyc < s + 7) @(negedge clk);
    check("abort_k4", o_acc_en && o_coeff == 3'd4,
          $sformatf("got acc_en=%0d k=%0d need 1/4", o_acc_en, o_coeff));
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle",
          !o_busy && !o_acc_en && !o_done && !o_wr_en && o_ovf == 2'b00 && o_rd_a == 4'd0,
          $sformatf("got busy=%0d acc_en=%0d done=%0d ovf=%b rd_a=%0d need 0",
                    o_busy, o_acc_en, o_done, o_ovf, o_rd_a));
    rst = 1'b0;
    m_reset();
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_done) done_cnt++;
    end
    check("abort_no_done", done_cnt == 0, $sformatf("got %0d dones need 0", done_cnt));
    mon_en = 1'b1;
    tab.delete();
    tab.push_back(2'b01);
    run_phase("after_abort");

    // Enable held low for five edges during MAC step 3 (scenario-1 timing).
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    done_at = -1;
    while (cyc < 30) begin
      vld = (cyc == 9) ? 2'b01 : 2'b00;
      ena = !(cyc >= 16 && cyc <= 20);
      @(negedge clk);
      if (cyc == 16)
        check("stall_k3", o_acc_en && o_rd_a == 4'd2 && o_rd_b == 4'd11 && o_coeff == 3'd3,
              $sformatf("got en=%0d a=%0d b=%0d k=%0d need 1/2/11/3",
                        o_acc_en, o_rd_a, o_rd_b, o_coeff));
      if (cyc >= 17 && cyc <= 21)
        check("stall_frozen",
              !o_acc_en && !o_acc_clr && !o_done && !o_wr_en && o_busy &&
              o_rd_a == 4'd2 && o_rd_b == 4'd11 && o_coeff == 3'd3,
              $sformatf("cyc %0d got en=%0d done=%0d a=%0d b=%0d k=%0d need 0/0/2/11/3",
                        cyc, o_acc_en, o_done, o_rd_a, o_rd_b, o_coeff));
      if (cyc == 22)
        check("stall_resume", o_acc_en && o_rd_a == 4'd3 && o_rd_b == 4'd10 && o_coeff == 3'd4,
              $sformatf("got en=%0d a=%0d b=%0d k=%0d need 1/3/10/4",
                        o_acc_en, o_rd_a, o_rd_b, o_coeff));
      if (o_done && done_at < 0) done_at = cyc;
    end
    ena = 1'b1;
    check("stall_done", done_at == 26, $sformatf("got done at %0d need 26", done_at));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filt_mac_sched.md
Name: filt_mac_sched

Overview:
- Multichannel scheduler/sequencer that time-shares one serial FIR MAC datapath (filt_mac-style: one product per fast clock) between gp_num_ch sample streams.
- Tracks per-channel sample requests and arbitrates round-robin.
- Per channel, keeps a circular delay-line head pointer and drives the MAC with write/read tap addresses, coefficient address, accumulator control and a per-channel done strobe.
- Sits between the per-channel sample front-ends and the shared MAC/delay-line RAM/coefficient ROM.

Parameters:
- gp_num_ch, 2, number of channels sharing the MAC (>=1).
- gp_coeff_length, 16, filter length L (>=2).
- gp_symm, 1, 1 = symmetric coefficients; fold two taps per step, K = ceil(L/2) steps. 0 = K = L steps.

Ports:
- i_clk  in  1  fast clock; sole clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_ena  in  1  global enable; 0 freezes sequencing.
- i_smp_vld  in  gp_num_ch  one-cycle pulse per channel: new input sample held by front-end.
- o_ch  out  clog2(gp_num_ch) (min 1)  channel currently served.
- o_wr_en  out  1  write new sample into o_ch delay line at o_wr_addr.
- o_wr_addr  out  clog2(L)  delay-line write address.
- o_rd_addr_a  out  clog2(L)  tap k address.
- o_rd_addr_b  out  clog2(L)  mirror tap L-1-k address (symmetric only).
- o_coeff_addr  out  clog2(K)  coefficient index k.
- o_acc_clr  out  1  first step of a result; load accumulator instead of adding.
- o_acc_en  out  1  MAC step valid.
- o_fold_en  out  1  add tap b before multiply.
- o_done  out  1  one-cycle result-valid strobe.
- o_done_ch  out  clog2(gp_num_ch)  channel of o_done.
- o_busy  out  1  FSM not IDLE.
- o_ovf  out  gp_num_ch  sticky per-channel overrun flag.

Behaviour:
- Reset (sync, i_rst=1 at posedge): FSM=IDLE; all outputs 0; pending=0; o_ovf=0; all heads=0; RR pointer=0. Reset mid-operation aborts with no o_done.
- All outputs registered.
- pending[c] is set the cycle after i_smp_vld[c].
- i_smp_vld[c] while pending[c]=1 and not being consumed this cycle: set o_ovf[c] (sticky until reset); the request is merged.
- Simultaneous consume (LOAD of c) and new i_smp_vld[c]: pending stays 1; no overflow.
- FSM states:
  - IDLE: if any pending, go to LOAD.
  - LOAD (1 cycle): the arbitrated channel is selected round-robin, starting at rr_ptr. head[c] <= head[c]-1 mod L. o_wr_en=1, o_wr_addr=new head. Clear pending[c]. rr_ptr <= c+1 mod N.
  - MAC (K cycles, k=0..K-1):
    - o_acc_en=1; o_acc_clr=(k==0); o_coeff_addr=k.
    - o_rd_addr_a=(head+k) mod L; o_rd_addr_b=(head+L-1-k) mod L.
    - o_fold_en=gp_symm and not (L odd and k==K-1), because the middle tap is unfolded.
  - DONE (1 cycle): o_done=1, o_done_ch=c. Then LOAD if any pending, else IDLE.
- Latency: i_smp_vld at cycle t, idle scheduler → LOAD t+2, MAC t+3..t+2+K, o_done t+3+K.
- Service time per channel is K+2 cycles. The integrator guarantees N*(K+2) <= fast clocks per sample period.
- i_ena=0: FSM, k counter, heads and rr_ptr hold. o_wr_en/o_acc_en/o_acc_clr/o_done forced 0; addresses hold. Pending/ovf capture continues.
- Modulo wrap: non-power-of-2 L wraps by compare-and-subtract, not bit truncation.
- Datapath read latency alignment is the datapath's responsibility; all strobes here are address-cycle aligned.

Decomposition:
- Package filt_mac_pkg:
  - state enum (IDLE/LOAD/MAC/DONE);
  - localparam function for K = gp_symm ? (L+1)/2 : L;
  - clog2 helper;
  - modulo-add function.
- One sub-module: filt_mac_rr_arb. Inputs: pending vector and rr_ptr. Outputs: grant index and grant-valid. Purely combinational; instantiated once.

Test Plan:
- Config for tests 1-3, 5 and 6: N=2, L=16, symm=1, K=8.
- 1. i_smp_vld[0] at cycle 10 after reset. Required: LOAD at 12 with o_wr_addr=15. MAC at 13-20: rd_a 15,0,1..6; rd_b 14,13..7; coeff 0..7; o_acc_clr only at 13. o_done=1, o_done_ch=0 at 21.
- 2. i_smp_vld=2'b11 at cycle 10. Required: ch0 done at 21 (DONE→LOAD direct); ch1 LOAD 22, o_wr_addr=15, done at 31. Next simultaneous pair is served ch0 first again, because rr_ptr returned to 0.
- 3. i_smp_vld[1] pulses at cycles 10 and 11. Required: o_ovf=2'b10 from cycle 12 and held; only one o_done for ch1.
- 4. Config N=1, L=15, symm=1 (K=8), one request. Required: o_fold_en=1 for k=0..6, 0 at k=7; rd_a at k=7 = (14+7) mod 15 = 6.
- 5. i_rst pulsed at MAC step k=4. Required: next cycle o_busy=0, no o_done, heads=0. A new request then writes addr 15.
- 6. i_ena=0 for 5 cycles during MAC k=3. Required: addresses frozen, o_acc_en=0, o_done delayed exactly 5 cycles (at 26 in scenario-1 timing).
